// File: rtl/test_mailbox_pkg.sv
// Shared constants for the test mailbox: register map, STATUS bit positions, watchdog default.
package test_mailbox_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  localparam logic [ADDR_W-1:0] ADDR_PROGRESS = 5'h00;
  localparam logic [ADDR_W-1:0] ADDR_PASS     = 5'h04;
  localparam logic [ADDR_W-1:0] ADDR_FAIL     = 5'h08;
  localparam logic [ADDR_W-1:0] ADDR_WDOG     = 5'h0C;
  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 5'h10;

  localparam int unsigned STAT_PASS     = 0;
  localparam int unsigned STAT_FAIL     = 1;
  localparam int unsigned STAT_TIMEOUT  = 2;
  localparam int unsigned STAT_OVERFLOW = 3;

  localparam logic [DATA_W-1:0] WDOG_DEFAULT_C = 32'd100000;

  // Assemble the read-only STATUS word from its flag bits.
  function automatic logic [DATA_W-1:0] status_word(input logic pass_set, input logic fail_set,
                                                    input logic timed_out, input logic overflow);
    logic [DATA_W-1:0] s;
    s                = '0;
    s[STAT_PASS]     = pass_set;
    s[STAT_FAIL]     = fail_set;
    s[STAT_TIMEOUT]  = timed_out;
    s[STAT_OVERFLOW] = overflow;
    return s;
  endfunction

endpackage

// File: rtl/test_mailbox_fifo.sv
// Synchronous power-of-two FIFO; push is accepted when not full or when a pop happens in the same cycle.
module test_mailbox_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push_c;
  logic             do_pop_c;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];
  assign do_pop_c  = out_valid && out_ready;
  assign do_push_c = in_valid && (!full || do_pop_c);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push_c) - (AW+1)'(do_pop_c);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/test_mailbox.sv
// CPU-visible test mailbox: PROGRESS/PASS/FAIL registers, progress-change event FIFO, optional watchdog.
// Watchdog is built only when TEST_MAILBOX_WATCHDOG_EN is defined.
module test_mailbox
  import test_mailbox_pkg::*;
#(
  parameter int unsigned       FIFO_DEPTH   = 4,
  parameter logic [DATA_W-1:0] WDOG_DEFAULT = WDOG_DEFAULT_C
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_req,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic              bus_ack,
  output logic [DATA_W-1:0] bus_rdata,
  output logic [DATA_W-1:0] test_progress,
  output logic [DATA_W-1:0] test_pass,
  output logic [DATA_W-1:0] test_fail,
  output logic              test_done,
  output logic              timeout,
  output logic              evt_valid,
  output logic [DATA_W-1:0] evt_data,
  input  logic              evt_ready,
  output logic              evt_overflow
);

  logic              take_c;
  logic              wr_c;
  logic              rd_c;
  logic              push_c;
  logic              fifo_full_c;
  logic              fifo_empty_c;
  logic [DATA_W-1:0] wdog_rd_c;
  logic [DATA_W-1:0] rd_val_c;

  // A request is taken only when no ack is in flight, so a held request acks every other cycle.
  assign take_c = bus_req && !bus_ack;
  assign wr_c   = take_c && bus_we;
  assign rd_c   = take_c && !bus_we;
  assign push_c = wr_c && (bus_addr == ADDR_PROGRESS) && (bus_wdata != test_progress);

  test_mailbox_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_valid (push_c),
    .in_data  (bus_wdata),
    .out_valid(evt_valid),
    .out_data (evt_data),
    .out_ready(evt_ready),
    .full     (fifo_full_c),
    .empty    (fifo_empty_c)
  );

  always_comb begin
    rd_val_c = '0;
    case (bus_addr)
      ADDR_PROGRESS: rd_val_c = test_progress;
      ADDR_PASS:     rd_val_c = test_pass;
      ADDR_FAIL:     rd_val_c = test_fail;
      ADDR_WDOG:     rd_val_c = wdog_rd_c;
      ADDR_STATUS:   rd_val_c = status_word(|test_pass, |test_fail, timeout, evt_overflow);
      default:       rd_val_c = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_ack       <= 1'b0;
      bus_rdata     <= '0;
      test_progress <= '0;
      test_pass     <= '0;
      test_fail     <= '0;
      test_done     <= 1'b0;
      evt_overflow  <= 1'b0;
    end else begin
      bus_ack   <= take_c;
      bus_rdata <= rd_c ? rd_val_c : '0;
      if (wr_c) begin
        case (bus_addr)
          ADDR_PROGRESS: test_progress <= bus_wdata;
          ADDR_PASS:     if (!test_done) test_pass <= bus_wdata;
          ADDR_FAIL:     if (!test_done) test_fail <= bus_wdata;
          default:       ;
        endcase
      end
      // A simultaneous pop frees a slot, so only a push into a full, non-draining FIFO drops.
      if (push_c && fifo_full_c && !(evt_ready && !fifo_empty_c)) evt_overflow <= 1'b1;
      test_done <= test_done || (test_pass != '0) || (test_fail != '0) || timeout;
    end
  end

`ifdef TEST_MAILBOX_WATCHDOG_EN
  logic [DATA_W-1:0] wdog_limit;
  logic [DATA_W-1:0] wdog_count;

  assign wdog_rd_c = wdog_limit;

  // A PROGRESS write or a new limit restarts the count; limit 0 never fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_limit <= WDOG_DEFAULT;
      wdog_count <= '0;
      timeout    <= 1'b0;
    end else begin
      if (wr_c && (bus_addr == ADDR_WDOG)) wdog_limit <= bus_wdata;
      if (wr_c && ((bus_addr == ADDR_PROGRESS) || (bus_addr == ADDR_WDOG))) begin
        wdog_count <= '0;
      end else if (!test_done) begin
        wdog_count <= wdog_count + DATA_W'(1);
      end
      if (!test_done && (wdog_limit != '0) && (wdog_count == wdog_limit)) timeout <= 1'b1;
    end
  end
`else
  logic [DATA_W-1:0] unused_wdog_default;

  assign unused_wdog_default = WDOG_DEFAULT;
  assign wdog_rd_c           = '0;
  assign timeout             = 1'b0;
`endif

endmodule

// File: doc/test_mailbox.md
TEST_MAILBOX -- requirements
Module: test_mailbox

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, progress-event FIFO depth (power of 2, 2..16).
REQ-002 SHALL have parameter WDOG_DEFAULT, default 32'd100000, watchdog limit after reset.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports bus_req in 1, bus_we in 1, bus_addr in 5 (byte address), bus_wdata in 32: CPU-side register access.
REQ-006 SHALL have ports bus_ack out 1, bus_rdata out 32: access completion and read data.
REQ-007 SHALL have outputs test_progress 32, test_pass 32, test_fail 32: register contents for the bench monitor.
REQ-008 SHALL have outputs test_done 1 (pass, fail or timeout latched) and timeout 1.
REQ-009 SHALL have ports evt_valid out 1, evt_data out 32, evt_ready in 1: progress-change event stream to the monitor.
REQ-010 SHALL have output evt_overflow 1: sticky flag for a dropped event.

Function
REQ-011 Map: 0x00 PROGRESS RW, 0x04 PASS RW, 0x08 FAIL RW, 0x0C WDOG_LIMIT RW, 0x10 STATUS RO {28'b0, overflow, timeout, fail!=0, pass!=0}; other addresses read 0, writes ignored.
REQ-012 bus_ack SHALL pulse exactly one cycle, one cycle after a sampled bus_req; bus_req held high gives one ack every second cycle, with no back-to-back acks.
REQ-013 bus_rdata SHALL be valid with bus_ack and SHALL be 0 otherwise.
REQ-014 A PROGRESS write with data different from the current value SHALL push the new value into the FIFO; a write of an equal value pushes nothing.
REQ-015 FIFO full on push SHALL drop the new value and set evt_overflow; existing entries are kept.
REQ-016 evt_valid SHALL be high while the FIFO is non-empty; evt_data is the oldest entry; pop on evt_valid && evt_ready.
REQ-017 Simultaneous push and pop on a full FIFO SHALL succeed without overflow; pointers wrap modulo FIFO_DEPTH.
REQ-018 PASS/FAIL writes after test_done is set SHALL be ignored; the first terminating event wins.
REQ-019 test_done SHALL assert the cycle after the terminating write's ack, or after timeout sets.
REQ-020 Writes of 0 to PASS or FAIL before test_done SHALL be stored but SHALL NOT set test_done.

Reset
REQ-021 On rst: all registers 0, WDOG_LIMIT=WDOG_DEFAULT, FIFO empty, evt_valid=0, evt_overflow=0, bus_ack=0, bus_rdata=0, test_done=0, timeout=0, watchdog count 0.
REQ-022 rst asserted mid-access SHALL abort the access; no ack is produced after reset releases.

Configuration
REQ-023 Macro TEST_MAILBOX_WATCHDOG_EN defined: a 32-bit counter increments every cycle while !test_done; timeout sets when count == WDOG_LIMIT (limit 0 disables); a PROGRESS write clears the counter.
REQ-024 Without the macro: no counter; timeout tied to 0; WDOG_LIMIT reads 0 and ignores writes; STATUS bit 2 is 0.

Structure
REQ-025 Package test_mailbox_pkg SHALL hold register offset constants, STATUS bit indices and WDOG_DEFAULT.
REQ-026 The FIFO SHALL be a sub-module test_mailbox_fifo (synchronous, valid/ready, full/empty, parameter DEPTH).

Verification
REQ-027 Write PROGRESS 0x11, 0x22, 0x22 with evt_ready=1 -> two events, 0x11 then 0x22; acks one cycle after each req.
REQ-028 evt_ready=0, five distinct PROGRESS writes (FIFO_DEPTH=4) -> evt_overflow=1; drain yields the first four values in order.
REQ-029 Write FAIL=0xDEAD then PASS=0x1 -> test_done=1, test_fail=0xDEAD, test_pass=0; STATUS reads 0x2.
REQ-030 With the macro, WDOG_LIMIT=50, no PROGRESS writes -> timeout and test_done at cycle 51 after the write; without the macro, both stay 0.
REQ-031 Assert rst during a pending read of 0x00 -> no bus_ack; all outputs return to reset values.
REQ-032 Read 0x14 -> bus_rdata=0; write 0x18 -> ack only, no state change.
